// File: rtl/alu_pkg.sv
// Shared definitions for the seq_alu execute unit: FSM state encoding,
// funct3 decodes for base, branch and M-extension ops, and the M funct7.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Base integer ops
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch conditions
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // M-extension ops
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes. start loads the operands;
// one quotient bit is produced per cycle. done is asserted during the final
// iteration, and quotient/remainder then carry the completed values so the
// caller can latch them on that same edge.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);
  localparam int SHW = $clog2(XLEN);

  logic            busy;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN:0]   shifted, diff;
  logic            fits;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    fits      = shifted >= {1'b0, dvs_q};
    diff      = shifted - {1'b0, dvs_q};
    remainder = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quotient  = {quo_q[XLEN-2:0], fits};
    done      = busy && (cnt == SHW'(XLEN - 1));
  end

  // Iteration state; clear aborts an in-flight divide.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      busy  <= 1'b0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (busy) begin
      quo_q <= quotient;
      rem_q <= remainder;
      cnt   <= cnt + SHW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked RV32I/RV32M execute unit. Base and branch ops finish in one
// registered cycle; multiply and divide iterate XLEN cycles, with the sign
// fix folded into the final iteration edge.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready
// (and no kill); a result transfers on a rising edge where
// out_valid && out_ready. result/br_taken stay stable while out_valid is
// high and out_ready is low.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op_imm,
  input  logic            is_branch,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0]   ONE_X  = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);

  state_t state, state_next;

  logic              accept, is_m, is_mul, is_div;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b, base_res;
  logic [SHW-1:0]    shamt;
  logic              br_cond, eq, lt_s, lt_u;

  logic [SHW-1:0]    cnt;
  logic [XLEN-1:0]   a_q, mag_a_q, res_q;
  logic [2*XLEN-1:0] prod_q, prod_step, prod_fix;
  logic [XLEN:0]     sum;
  logic [2:0]        f3_q;
  logic              neg_q, sa_q, div0_q, br_q, last_iter;
  logic [XLEN-1:0]   mul_res, div_res, quo_fix, rem_fix;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic              div_done;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign br_taken  = br_q;
  assign accept    = in_valid && in_ready && !kill;
  assign last_iter = (cnt == SHW'(XLEN - 1));

  // Decode, operand magnitudes, single-cycle ALU and branch compare.
  always_comb begin
    is_m     = !op_imm && !is_branch && (funct7 == FUNCT7_M);
    is_mul   = is_m && !funct3[2];
    is_div   = is_m && funct3[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_mul) begin
      a_signed = (funct3 != F3_MULHU);
      b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH);
    end else if (is_div) begin
      a_signed = !funct3[0];
      b_signed = !funct3[0];
    end
    sign_a = a_signed && src_a[XLEN-1];
    sign_b = b_signed && src_b[XLEN-1];
    mag_a  = sign_a ? (~src_a + ONE_X) : src_a;
    mag_b  = sign_b ? (~src_b + ONE_X) : src_b;

    shamt = src_b[SHW-1:0];
    eq    = (src_a == src_b);
    lt_s  = ($signed(src_a) < $signed(src_b));
    lt_u  = (src_a < src_b);

    base_res = '0;
    case (funct3)
      F3_ADD:  base_res = (!op_imm && funct7[5]) ? (src_a - src_b) : (src_a + src_b);
      F3_SLL:  base_res = src_a << shamt;
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  base_res = src_a ^ src_b;
      F3_SR:   base_res = funct7[5] ? XLEN'($signed(src_a) >>> shamt) : (src_a >> shamt);
      F3_OR:   base_res = src_a | src_b;
      default: base_res = src_a & src_b;
    endcase

    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = eq;
      F3_BNE:  br_cond = !eq;
      F3_BLT:  br_cond = lt_s;
      F3_BGE:  br_cond = !lt_s;
      F3_BLTU: br_cond = lt_u;
      F3_BGEU: br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  // Multiply step plus sign restoration, and divide sign/special-case fixup.
  always_comb begin
    sum       = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    prod_step = {sum, prod_q[XLEN-1:1]};
    prod_fix  = neg_q ? (~prod_step + ONE_2X) : prod_step;
    mul_res   = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    quo_fix = div0_q ? '1 : (neg_q ? (~div_quo + ONE_X) : div_quo);
    rem_fix = div0_q ? a_q : (sa_q ? (~div_rem + ONE_X) : div_rem);
    div_res = f3_q[1] ? rem_fix : quo_fix;
  end

  // Next-state logic; kill wins over everything else.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? MUL : (is_div ? DIV : DONE);
      MUL:  if (last_iter) state_next = DONE;
      DIV:  if (div_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture, multiply iteration and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      a_q     <= '0;
      mag_a_q <= '0;
      prod_q  <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else if (kill) begin
      cnt <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        a_q     <= src_a;
        mag_a_q <= mag_a;
        prod_q  <= {{XLEN{1'b0}}, mag_b};
        f3_q    <= funct3;
        neg_q   <= sign_a ^ sign_b;
        sa_q    <= sign_a;
        div0_q  <= (src_b == '0);
        if (!is_m) begin
          res_q <= is_branch ? '0 : base_res;
          br_q  <= is_branch && br_cond;
        end
      end
      if (state == MUL) begin
        prod_q <= prod_step;
        cnt    <= cnt + SHW'(1);
        if (last_iter) begin
          res_q <= mul_res;
          br_q  <= 1'b0;
        end
      end
      if (state == DIV) begin
        cnt <= cnt + SHW'(1);
        if (div_done) begin
          res_q <= div_res;
          br_q  <= 1'b0;
        end
      end
    end
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (kill),
    .start    (accept && is_div),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

endmodule
